flash_pp_controller: RTL and testbench
======================================

# flash_pp_controller

SPI-flash page-program sequencer for an M25P16-compatible serial NOR device. A single-cycle `key_flag` pulse starts one complete write: Write Enable (0x06), a chip-select gap, then Page Program (0x02) with a 24-bit address and a fixed block of incrementing data bytes. It sits between the debounced-key logic and the flash pins, drives SCK/CS#/MOSI directly, and never reads MISO.

## Interface
- `WR_EN_INST`, 8'h06: Write Enable opcode.
- `PP_INST`, 8'h02: Page Program opcode.
- `ADDR`, 24'h00_04_25: program start address, sent MSB first.
- `NUM_DATA`, 100: data bytes per program, 1..256. Data byte i equals i[7:0].
- `sys_clk` input 1: system clock, 50 MHz.
- `sys_rst_n` input 1: reset, asynchronous and active-low.
- `key_flag` input 1: start pulse, one `sys_clk` wide.
- `sck` output 1: SPI clock, mode 0, `sys_clk`/4.
- `cs_n` output 1: flash chip select, active low.
- `mosi` output 1: serial data to flash, MSB first.

## Operation
- States:
  - IDLE: waiting for a start.
  - WR_EN: Write Enable transaction.
  - DELAY: deselect gap.
  - PP: Page Program transaction.
- Timing units:
  - Slot: 32 `sys_clk` cycles, counted by `cnt_clk` 0..31.
  - Slot index: `cnt_byte`.
  - Bit cell: 4 cycles, counted by `cnt_sck` 0..3.
  - `cnt_bit` runs 7..0 within a transmit slot.
- Start:
  - IDLE → WR_EN when `key_flag`=1.
  - `key_flag` in any other state is ignored. No queuing.
- WR_EN has 3 slots:
  - Slot 0: `cs_n` low, no clocks (setup).
  - Slot 1: shift `WR_EN_INST`.
  - Slot 2: hold, no clocks.
  - At end of slot 2: `cs_n`=1, go to DELAY.
- DELAY: 1 slot with `cs_n` high (≥100 ns deselect), then go to PP.
- PP has NUM_DATA+6 slots:
  - Slot 0: `cs_n` low, setup.
  - Slot 1: `PP_INST`.
  - Slots 2–4: `ADDR[23:16]`, `[15:8]`, `[7:0]`.
  - Slots 5..NUM_DATA+4: data bytes 0..NUM_DATA-1.
  - Final slot: hold.
  - At end of final slot: `cs_n`=1, counters clear, go to IDLE.
- Transmit slot bit cell, for each of the 8 bits:
  - `mosi` loads the current bit at `cnt_sck`=0, and also on the first cycle of the slot.
  - `sck`=0 for `cnt_sck` 0–1 and `sck`=1 for `cnt_sck` 2–3.
  - The flash samples on the rising edge, mid-bit.
- Outside transmit slots: `sck`=0 and `mosi`=0.
- Page wrap past a 256-byte boundary is the flash's behaviour. The controller does not split pages.
- Reset, including mid-transaction:
  - Returns immediately to IDLE with all counters 0.
  - `sck`=0, `cs_n`=1, `mosi`=0.
  - An interrupted PP is not committed by the flash.

## Timing
- All outputs are registered from `sys_clk`. Reset values: `sck`=0, `cs_n`=1, `mosi`=0.
- Key pulse sampled at edge N: `cs_n` falls at edge N+1.
- WR_EN length: 96 cycles. First SCK rise at 32+2 cycles after the `cs_n` fall.
- DELAY length: 32 cycles with `cs_n` high.
- PP length: (NUM_DATA+6)×32 cycles, which is 3392 cycles at default.
- Total from key to return to IDLE: 3520 cycles, 70.4 µs at 50 MHz.
- Each transmit slot produces exactly 8 `sck` rising edges. Bytes per transaction:
  - WR_EN: 1 byte.
  - PP: NUM_DATA+4 bytes.
- `mosi` is stable for ≥2 cycles before and after each `sck` rising edge.
- `cs_n` is not toggled by a back-to-back key pulse while busy.

## Test plan
- Reset check: hold reset 30 ns, release, run 1 µs idle. Expect `sck`=0, `cs_n`=1, `mosi`=0 throughout, with no SCK edges.
- WREN frame: pulse `key_flag` 20 ns at t≈1030 ns.
  - `cs_n` low for 96 cycles.
  - 8 SCK rises sampling 0x06.
  - Then `cs_n` high for exactly 32 cycles.
- PP frame:
  - Second `cs_n` low window lasts 3392 cycles.
  - 832 SCK rises decode to 0x02, 0x00, 0x04, 0x25, then 0x00..0x63.
  - `cs_n` returns high and the FSM is in IDLE.
- Flash model:
  - After the program time of the M25P16 model, wired with `w`=1 and `hold`=1, bytes 0x000425..0x000488 hold 0x00..0x63.
  - Neighbouring bytes keep their init-file values.
- Busy ignore: second `key_flag` pulse during PP. Expect no extra `cs_n` frame and identical total length.
- Reset mid-PP: assert reset at address byte 2. Expect outputs at reset values immediately, flash memory unchanged, and a new key pulse running a full correct sequence.

Source files
------------

// File: rtl/flash_pp_controller.sv
// flash_pp_controller: one key pulse runs Write Enable, a deselect gap, then a
// Page Program of NUM_DATA incrementing bytes to a serial NOR flash (SPI mode 0).
// All pin outputs are registered, so pins lag the FSM/counters by one cycle.
module flash_pp_controller #(
    parameter logic [7:0]  WR_EN_INST = 8'h06,
    parameter logic [7:0]  PP_INST    = 8'h02,
    parameter logic [23:0] ADDR       = 24'h00_04_25,
    parameter int          NUM_DATA   = 100
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_flag,
    output logic sck,
    output logic cs_n,
    output logic mosi
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_EN = 2'd1,
        DELAY = 2'd2,
        PP    = 2'd3
    } state_t;

    // Index of the trailing hold slot of the Page Program transaction.
    localparam logic [8:0] PP_LAST_SLOT = 9'(NUM_DATA + 5);

    state_t     state_q, state_d;
    logic [4:0] cnt_clk_q, cnt_clk_d;    // cycle within a 32-cycle slot
    logic [8:0] cnt_byte_q, cnt_byte_d;  // slot index within a transaction
    logic       sck_q, sck_d;
    logic       cs_n_q, cs_n_d;
    logic       mosi_q, mosi_d;

    logic       slot_end;
    logic       tx_active;
    logic [7:0] tx_byte;
    logic [2:0] cnt_bit;

    // Byte shifted in each Page Program slot: opcode, address MSB first, then data i = i[7:0].
    function automatic logic [7:0] pp_byte(input logic [8:0] slot);
        logic [8:0] idx;
        idx = slot - 9'd5;
        case (slot)
            9'd1:    pp_byte = PP_INST;
            9'd2:    pp_byte = ADDR[23:16];
            9'd3:    pp_byte = ADDR[15:8];
            9'd4:    pp_byte = ADDR[7:0];
            default: pp_byte = idx[7:0];
        endcase
    endfunction

    assign slot_end = (cnt_clk_q == 5'd31);
    // Each bit cell is 4 cycles, so cnt_clk[4:2] walks the 8 bits MSB first.
    assign cnt_bit  = 3'd7 - cnt_clk_q[4:2];

    // State and slot counters; reset drops any transaction in progress.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            cnt_clk_q  <= 5'd0;
            cnt_byte_q <= 9'd0;
        end else begin
            state_q    <= state_d;
            cnt_clk_q  <= cnt_clk_d;
            cnt_byte_q <= cnt_byte_d;
        end
    end

    // Next-state: slots of 32 cycles, leaving each state at the end of its last slot.
    always_comb begin
        state_d    = state_q;
        cnt_clk_d  = cnt_clk_q;
        cnt_byte_d = cnt_byte_q;
        case (state_q)
            IDLE: begin
                if (key_flag) begin
                    state_d    = WR_EN;
                    cnt_clk_d  = 5'd0;
                    cnt_byte_d = 9'd0;
                end
            end
            WR_EN: begin
                cnt_clk_d = cnt_clk_q + 5'd1;
                if (slot_end) begin
                    if (cnt_byte_q == 9'd2) begin
                        state_d    = DELAY;
                        cnt_byte_d = 9'd0;
                    end else begin
                        cnt_byte_d = cnt_byte_q + 9'd1;
                    end
                end
            end
            DELAY: begin
                cnt_clk_d = cnt_clk_q + 5'd1;
                if (slot_end) begin
                    state_d    = PP;
                    cnt_byte_d = 9'd0;
                end
            end
            PP: begin
                cnt_clk_d = cnt_clk_q + 5'd1;
                if (slot_end) begin
                    if (cnt_byte_q == PP_LAST_SLOT) begin
                        state_d    = IDLE;
                        cnt_clk_d  = 5'd0;
                        cnt_byte_d = 9'd0;
                    end else begin
                        cnt_byte_d = cnt_byte_q + 9'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pin next-values: first and last slot of a transaction are setup/hold with no clocks.
    always_comb begin
        tx_active = 1'b0;
        tx_byte   = 8'h00;
        case (state_q)
            WR_EN: begin
                tx_active = (cnt_byte_q == 9'd1);
                tx_byte   = WR_EN_INST;
            end
            PP: begin
                tx_active = (cnt_byte_q != 9'd0) && (cnt_byte_q != PP_LAST_SLOT);
                tx_byte   = pp_byte(cnt_byte_q);
            end
            default: begin
                tx_active = 1'b0;
                tx_byte   = 8'h00;
            end
        endcase
        cs_n_d = (state_q == IDLE) || (state_q == DELAY);
        // SCK high in the second half of the bit cell so MOSI has settled 2 cycles earlier.
        sck_d  = tx_active && cnt_clk_q[1];
        mosi_d = tx_active && tx_byte[cnt_bit];
    end

    // Registered pins, idle levels on reset.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sck_q  <= 1'b0;
            cs_n_q <= 1'b1;
            mosi_q <= 1'b0;
        end else begin
            sck_q  <= sck_d;
            cs_n_q <= cs_n_d;
            mosi_q <= mosi_d;
        end
    end

    assign sck  = sck_q;
    assign cs_n = cs_n_q;
    assign mosi = mosi_q;

endmodule

// File: tb/tb_flash_pp_controller.sv
// Bench for flash_pp_controller: an SPI monitor decodes frames and acts as a
// minimal serial NOR model; the stimulus block pushes expected bytes/frames
// into scoreboards and compares them as the DUT produces them.
module tb_flash_pp_controller;

    localparam int NUM_DATA = 100;

    logic sys_clk = 1'b0;
    logic sys_rst_n;
    logic key_flag;
    logic sck, cs_n, mosi;

    flash_pp_controller #(
        .WR_EN_INST(8'h06),
        .PP_INST   (8'h02),
        .ADDR      (24'h00_04_25),
        .NUM_DATA  (NUM_DATA)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .key_flag (key_flag),
        .sck      (sck),
        .cs_n     (cs_n),
        .mosi     (mosi)
    );

    always #10 sys_clk = ~sys_clk;

    typedef struct {
        int len;
        int bits;
    } frame_t;

    // Observations, written only by the monitor.
    logic [7:0] obs_byte[$];
    frame_t     obs_frame[$];
    int         obs_gap[$];
    int         stray_sck;
    bit [7:0]   mem[0:2047];
    bit         wmask[0:2047];

    // Expectations and counters, owned by the stimulus block.
    logic [7:0] exp_byte[$];
    frame_t     exp_frame[$];
    int         by_ptr;
    int         fr_ptr;
    int         checks;
    int         errors;

    function automatic logic [7:0] mem_rd(input int a);
        logic [31:0] av;
        av = a;
        return wmask[av[10:0]] ? mem[av[10:0]] : 8'hFF;
    endfunction

    // SPI monitor + flash model: sample on falling sys_clk, commit PP on CS# rise.
    initial begin : monitor
        int         low_len, high_len, bitcnt;
        logic       prev_sck, prev_cs, wel;
        logic [7:0] sh;
        logic [7:0] fb[$];
        logic [23:0] a, wa;
        low_len = 0; high_len = 0; bitcnt = 0; stray_sck = 0;
        prev_sck = 1'b0; prev_cs = 1'b1; wel = 1'b0; sh = 8'h00;
        forever begin
            @(negedge sys_clk);
            if (cs_n !== 1'b0) begin
                if (!prev_cs) begin
                    obs_frame.push_back('{low_len, bitcnt});
                    if (fb.size() == 1 && fb[0] == 8'h06 && bitcnt == 8) begin
                        wel = 1'b1;
                    end else begin
                        if (fb.size() >= 5 && fb[0] == 8'h02 && wel && (bitcnt % 8) == 0) begin
                            a = {fb[1], fb[2], fb[3]};
                            for (int k = 0; k < fb.size() - 4; k++) begin
                                wa = {a[23:8], 8'(a[7:0] + 8'(k))};
                                mem[wa[10:0]]   = fb[k + 4];
                                wmask[wa[10:0]] = 1'b1;
                            end
                            wel = 1'b0;
                        end
                    end
                    high_len = 0;
                end
                high_len++;
                if (sck === 1'b1 && !prev_sck) stray_sck++;
            end else begin
                if (prev_cs) begin
                    obs_gap.push_back(high_len);
                    low_len = 0;
                    bitcnt  = 0;
                    fb.delete();
                end
                low_len++;
                if (sck === 1'b1 && !prev_sck) begin
                    sh = {sh[6:0], mosi};
                    bitcnt++;
                    if ((bitcnt % 8) == 0) begin
                        obs_byte.push_back(sh);
                        fb.push_back(sh);
                    end
                end
            end
            prev_sck = (sck === 1'b1);
            prev_cs  = (cs_n !== 1'b0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic pulse_key();
        @(negedge sys_clk);
        key_flag = 1'b1;
        @(negedge sys_clk);
        key_flag = 1'b0;
    endtask

    // Expectations for one complete WREN + PP sequence.
    task automatic push_full();
        exp_byte.push_back(8'h06);
        exp_byte.push_back(8'h02);
        exp_byte.push_back(8'h00);
        exp_byte.push_back(8'h04);
        exp_byte.push_back(8'h25);
        for (int i = 0; i < NUM_DATA; i++) exp_byte.push_back(8'(i));
        exp_frame.push_back('{96, 8});
        exp_frame.push_back('{(NUM_DATA + 6) * 32, (NUM_DATA + 4) * 8});
    endtask

    // Pop/compare expectations as the monitor reports frames, bounded by a cycle budget.
    task automatic drain(input int budget);
        int     cyc;
        frame_t e, o;
        cyc = 0;
        while (exp_frame.size() > 0) begin
            while (fr_ptr >= obs_frame.size() && cyc < budget) begin
                @(posedge sys_clk);
                cyc++;
            end
            if (fr_ptr >= obs_frame.size()) begin
                chk("frames_seen", obs_frame.size(), fr_ptr + exp_frame.size());
                exp_frame.delete();
            end else begin
                e = exp_frame.pop_front();
                o = obs_frame[fr_ptr];
                fr_ptr++;
                chk("frame_len", o.len, e.len);
                chk("frame_bits", o.bits, e.bits);
            end
        end
        while (exp_byte.size() > 0) begin
            if (by_ptr < obs_byte.size()) begin
                chk("spi_byte", obs_byte[by_ptr], exp_byte.pop_front());
                by_ptr++;
            end else begin
                chk("bytes_seen", obs_byte.size(), by_ptr + exp_byte.size());
                exp_byte.delete();
            end
        end
        chk("extra_bytes", obs_byte.size(), by_ptr);
        chk("gap_len", (obs_gap.size() > 0) ? obs_gap[obs_gap.size() - 1] : -1, 32);
        chk("cs_n_end", cs_n, 1'b1);
    endtask

    task automatic mem_check(input string tag);
        for (int i = 0; i < NUM_DATA; i++) chk(tag, mem_rd(32'h425 + i), 8'(i));
        chk("mem_below", mem_rd(32'h424), 8'hFF);
        chk("mem_above", mem_rd(32'h425 + NUM_DATA), 8'hFF);
    endtask

    initial begin : stim
        int gaps_before;
        checks = 0; errors = 0; by_ptr = 0; fr_ptr = 0;
        sys_rst_n = 1'b1;
        key_flag  = 1'b0;
        #2 sys_rst_n = 1'b0;
        #13;
        chk("rst_sck", sck, 1'b0);
        chk("rst_cs_n", cs_n, 1'b1);
        chk("rst_mosi", mosi, 1'b0);
        #27 sys_rst_n = 1'b1;

        // About 1 us of idle after reset release.
        for (int i = 0; i < 5; i++) begin
            repeat (10) @(negedge sys_clk);
            chk("idle_sck", sck, 1'b0);
            chk("idle_cs_n", cs_n, 1'b1);
            chk("idle_mosi", mosi, 1'b0);
        end
        chk("idle_stray_sck", stray_sck, 0);
        chk("idle_no_frame", obs_gap.size(), 0);

        // Full WREN + PP sequence.
        push_full();
        pulse_key();
        drain(8000);
        mem_check("mem_pp1");

        // Busy ignore: a second key pulse during PP must not start anything.
        gaps_before = obs_gap.size();
        push_full();
        pulse_key();
        repeat (700) @(posedge sys_clk);
        pulse_key();
        drain(8000);
        repeat (300) @(posedge sys_clk);
        chk("busy_no_extra_frame", obs_gap.size(), gaps_before + 2);
        chk("busy_cs_n_idle", cs_n, 1'b1);

        // Reset in the middle of address byte 2 of PP.
        exp_byte.push_back(8'h06);
        exp_byte.push_back(8'h02);
        exp_byte.push_back(8'h00);
        exp_frame.push_back('{96, 8});
        exp_frame.push_back('{111, 20});
        pulse_key();
        repeat (240) @(posedge sys_clk);
        #1 sys_rst_n = 1'b0;
        #1;
        chk("midrst_sck", sck, 1'b0);
        chk("midrst_cs_n", cs_n, 1'b1);
        chk("midrst_mosi", mosi, 1'b0);
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        drain(200);
        mem_check("mem_after_abort");
        chk("stray_sck", stray_sck, 0);

        // A fresh key after the aborted write runs a complete sequence.
        push_full();
        pulse_key();
        drain(8000);
        mem_check("mem_pp2");
        chk("final_stray_sck", stray_sck, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
